// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner.
//   scan_state_e : scan FSM states (EMPTY before the first value, GUARD dead time, ON digit lit)
//   MAX_DIGITS   : widest display the scanner supports
//   an_polarity  : maps active-high digit enables onto the physical anode polarity
package disp_pkg;

   localparam int unsigned MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_GUARD,
      ST_ON
   } scan_state_e;

   function automatic logic [MAX_DIGITS-1:0] an_polarity(
      input logic [MAX_DIGITS-1:0] enables,
      input logic                  active_low
   );
      return active_low ? ~enables : enables;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-rate prescaler for multiplexed displays.
// Counts 0..DIV-1 while en is high and wraps; held at 0 while en is low.
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   en   in   count enable (low clears the count)
//   tick out  high during the last cycle of each slot (count == DIV-1)
module scan_prescaler #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned    CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = en && (count == LAST);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A packed hex value arrives over valid/ready; one digit is shown per scan slot,
// each slot starting with GUARD_CYC dead-time cycles (all enables off) against ghosting.
// A newly offered value waits in a single pending register and is swapped in only at
// a frame boundary, so a frame never mixes digits of two values.
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_value offered
//   in_ready   out  pending register free (transfer on in_valid && in_ready)
//   in_value   in   packed hex value, digit 0 in bits [3:0]
//   nibble     out  nibble of the digit currently scanned (to the 7-seg decoder)
//   digit_idx  out  index of the digit currently scanned
//   an         out  one-hot digit enables, polarity set by ACTIVE_LOW_AN
//   frame_done out  one-cycle pulse when the last digit's slot ends
// Optional build macro LEADING_ZERO_BLANK_EN: suppresses the enable of leading zero
// digits (digit 0 always shown); scan timing and digit_idx are unaffected.
module hex_display_scanner
   import disp_pkg::*;
#(
   parameter int unsigned N_DIGITS      = 4,
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned SCAN_HZ       = 1000,
   parameter int unsigned GUARD_CYC     = 4,
   parameter bit          ACTIVE_LOW_AN = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [4*N_DIGITS-1:0]       in_value,
   output logic [3:0]                  nibble,
   output logic [$clog2(N_DIGITS)-1:0] digit_idx,
   output logic [N_DIGITS-1:0]         an,
   output logic                        frame_done
);

   localparam int unsigned     DIV        = CLK_HZ / SCAN_HZ;
   localparam int unsigned     IDX_W      = $clog2(N_DIGITS);
   localparam int unsigned     GW         = $clog2(GUARD_CYC) + 1;
   localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

   scan_state_e            state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [GW-1:0]          guard_q, guard_d;
   logic [4*N_DIGITS-1:0]  value_q;
   logic [4*N_DIGITS-1:0]  pending_q;
   logic                   pending_full_q;
   logic                   tick;
   logic                   accept;
   logic                   frame_end;
   logic [N_DIGITS-1:0]    show_mask;
   logic [N_DIGITS-1:0]    enable_d;
   logic [N_DIGITS-1:0]    an_d;
   logic [3:0]             digit_nibble;

   scan_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != ST_EMPTY),
      .tick (tick)
   );

   assign in_ready     = !pending_full_q;
   assign accept       = in_valid && !pending_full_q;
   assign frame_end    = (state_q == ST_ON) && tick && (idx_q == LAST_IDX);
   assign digit_nibble = value_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   // Digit i is lit only if it or any more significant nibble is non-zero.
   always_comb begin
      show_mask    = '0;
      show_mask[0] = 1'b1;
      for (int unsigned i = 1; i < N_DIGITS; i++) begin
         show_mask[i] = (value_q >> (4 * i)) != '0;
      end
   end
`else
   assign show_mask = '1;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      guard_d  = guard_q;
      enable_d = '0;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_GUARD;
               idx_d   = '0;
               guard_d = '0;
            end
         end
         ST_GUARD: begin
            if (guard_q == GUARD_LAST) begin
               state_d = ST_ON;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         ST_ON: begin
            enable_d[idx_q] = show_mask[idx_q];
            if (tick) begin
               state_d = ST_GUARD;
               guard_d = '0;
               idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      an_d = N_DIGITS'(an_polarity(MAX_DIGITS'(enable_d), ACTIVE_LOW_AN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_EMPTY;
         idx_q          <= '0;
         guard_q        <= '0;
         value_q        <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         nibble         <= '0;
         digit_idx      <= '0;
         an             <= N_DIGITS'(an_polarity('0, ACTIVE_LOW_AN));
         frame_done     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         guard_q <= guard_d;
         // The first value after reset goes straight to the display; later ones
         // wait in pending. An accept needs pending empty and a swap needs it
         // full, so the two branches can never both apply in one cycle.
         if (accept) begin
            if (state_q == ST_EMPTY) begin
               value_q <= in_value;
            end else begin
               pending_q      <= in_value;
               pending_full_q <= 1'b1;
            end
         end else if (frame_end && pending_full_q) begin
            value_q        <= pending_q;
            pending_full_q <= 1'b0;
         end
         nibble     <= digit_nibble;
         digit_idx  <= idx_q;
         an         <= an_d;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (N_DIGITS=4, DIV=10, GUARD_CYC=2, active-low an).
// Stimulus queues the expected digit slots of each frame; a monitor pops one entry each
// time a digit enable turns on and compares index, nibble and anode pattern.
module tb_hex_display_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_value = '0;
   logic        in_ready;
   logic [3:0]  nibble;
   logic [1:0]  digit_idx;
   logic [3:0]  an;
   logic        frame_done;

   hex_display_scanner #(
      .N_DIGITS      (4),
      .CLK_HZ        (1000),
      .SCAN_HZ       (100),
      .GUARD_CYC     (2),
      .ACTIVE_LOW_AN (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .nibble     (nibble),
      .digit_idx  (digit_idx),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] idx;
      logic [3:0] nib;
      logic [3:0] an;
   } slot_t;

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  m;
   } frame_t;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0] M0005 = 4'b0001;
`else
   localparam logic [3:0] M0005 = 4'b1111;
`endif

   slot_t  sb_q[$];
   frame_t frame_q[$];
   int     errors    = 0;
   int     checks    = 0;
   int     cyc       = 0;
   int     frame_cnt = 0;

   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Expected slots of one frame; m selects which digits are lit.
   function automatic void push_frame(input logic [15:0] v, input logic [3:0] m);
      logic [3:0] a;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            a = 4'b0001 << i;
            a = ~a;
            sb_q.push_back('{idx: 2'(i), nib: v[4*i +: 4], an: a});
         end
      end
   endfunction

   // Monitor: one scoreboard pop per lit slot; checks lit length and dead time.
   bit         in_run     = 1'b0;
   bit         prev_valid = 1'b0;
   int         run_len    = 0;
   int         gap        = 0;
   always @(negedge clk) begin : mon
      slot_t e;
      if (rst) begin
         in_run     = 1'b0;
         prev_valid = 1'b0;
         run_len    = 0;
         gap        = 0;
      end else if (an !== 4'hF) begin
         if (!in_run) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_slot: got idx=%0d nib=%h an=%b, expected no lit digit (cycle %0d)",
                        digit_idx, nibble, an, cyc);
            end else begin
               e = sb_q.pop_front();
               chk("slot {idx,nib,an}", {22'd0, digit_idx, nibble, an}, {22'd0, e.idx, e.nib, e.an});
            end
`ifndef LEADING_ZERO_BLANK_EN
            if (prev_valid) chk("guard_gap", gap, 2);
`endif
            in_run  = 1'b1;
            run_len = 1;
         end else begin
            run_len++;
         end
      end else begin
         if (in_run) begin
            chk("slot_len", run_len, 8);
            in_run     = 1'b0;
            prev_valid = 1'b1;
            gap        = 1;
         end else begin
            gap++;
         end
      end
   end

   // Frame tracker: checks frame period and queues the next frame's expected slots.
   bit fd_prev_valid = 1'b0;
   int fd_prev       = 0;
   always @(negedge clk) begin : trk
      frame_t f;
      if (rst) begin
         fd_prev_valid = 1'b0;
      end else if (frame_done === 1'b1) begin
         if (fd_prev_valid) chk("frame_period", cyc - fd_prev, 40);
         fd_prev       = cyc;
         fd_prev_valid = 1'b1;
         frame_cnt++;
         if (frame_q.size() > 0) begin
            f = frame_q.pop_front();
            push_frame(f.v, f.m);
         end
      end
   end

   task automatic wait_fd(input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: frame_done got no pulse, expected one within 80 cycles", name);
      end
   endtask

   // Called just after a rising edge; returns after the accepting edge.
   task automatic offer(input logic [15:0] v, input bit keep, output int fr, output int stall);
      bit seen;
      seen  = 1'b0;
      stall = 0;
      fr    = -1;
      in_valid = 1'b1;
      in_value = v;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
         stall++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL offer_timeout: in_ready got 0 for 200 cycles, expected 1");
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         fr = frame_cnt;
         if (!keep) in_valid = 1'b0;
      end
   endtask

   initial begin : stim
      int  fr;
      int  st;
      bit  seen;

      // 1. reset and idle
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_an", an, 4'hF);
      chk("reset_ready", in_ready, 1);
      chk("reset_idx", digit_idx, 0);
      chk("reset_nibble", nibble, 0);
      chk("reset_frame_done", frame_done, 0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_an", an, 4'hF);
         chk("idle_ready", in_ready, 1);
         chk("idle_frame_done", frame_done, 0);
      end

      // 2. first value, loaded directly
      push_frame(16'h12AF, 4'hF);
      frame_q.push_back('{v: 16'h12AF, m: 4'hF});
      frame_q.push_back('{v: 16'h12AF, m: 4'hF});
      frame_q.push_back('{v: 16'h12AF, m: 4'hF});
      frame_q.push_back('{v: 16'h0005, m: M0005});
      frame_q.push_back('{v: 16'h3456, m: 4'hF});
      frame_q.push_back('{v: 16'h789B, m: 4'hF});
      frame_q.push_back('{v: 16'hCDE0, m: 4'hF});
      @(posedge clk);
      #1;
      offer(16'h12AF, 1'b0, fr, st);
      chk("stall_direct_load", st, 0);
      @(negedge clk);
      chk("ready_after_direct_load", in_ready, 1);
      repeat (3) wait_fd("frame_12AF");

      // 3. mid-frame update goes to pending
      repeat (15) @(negedge clk);
      @(posedge clk);
      #1;
      offer(16'h0005, 1'b0, fr, st);
      chk("accept_frame_0005", fr, 3);
      @(negedge clk);
      chk("ready_low_after_pending", in_ready, 0);
      repeat (5) @(negedge clk);
      chk("ready_still_stalled", in_ready, 0);
      wait_fd("frame_end_before_0005");
      chk("ready_after_swap", in_ready, 1);

      // 4. back-to-back values with in_valid held
      @(posedge clk);
      #1;
      offer(16'h3456, 1'b1, fr, st);
      chk("accept_frame_3456", fr, 4);
      chk("stall_3456", st, 0);
      offer(16'h789B, 1'b1, fr, st);
      chk("accept_frame_789B", fr, 5);
      chk("stall_789B", st, 38);
      offer(16'hCDE0, 1'b0, fr, st);
      chk("accept_frame_CDE0", fr, 6);
      chk("stall_CDE0", st, 39);

      // 5. reset while digit 2 is lit
      wait_fd("frame_end_789B");
      chk("ready_after_last_swap", in_ready, 1);
      seen = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (an === 4'b1011) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL digit2_on: an never got 1011 within 60 cycles, expected 1011");
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midscan_rst_an", an, 4'hF);
      chk("midscan_rst_idx", digit_idx, 0);
      chk("midscan_rst_ready", in_ready, 1);
      chk("midscan_rst_nibble", nibble, 0);
      chk("midscan_rst_frame_done", frame_done, 0);
      chk("slots_cut_by_rst", sb_q.size(), 1);
      chk("frames_unused", frame_q.size(), 0);
      sb_q.delete();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("post_rst_an", an, 4'hF);
      end

`ifdef LEADING_ZERO_BLANK_EN
      // 6. leading-zero blanking
      push_frame(16'h0030, 4'b0011);
      frame_q.push_back('{v: 16'h0030, m: 4'b0011});
      frame_q.push_back('{v: 16'h0000, m: 4'b0001});
      frame_q.push_back('{v: 16'h0000, m: 4'b0001});
      @(posedge clk);
      #1;
      offer(16'h0030, 1'b0, fr, st);
      wait_fd("lzb_frame0");
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      offer(16'h0000, 1'b0, fr, st);
      chk("lzb_ready_low", in_ready, 0);
      repeat (3) wait_fd("lzb_frames");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("lzb_rst_an", an, 4'hF);
`endif

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: bench still running at 200000 time units, expected to finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
